mem_access_unit: RTL and testbench

//  MEM stage directly downstream of the execute stage. Registers the EX results into an EX/MEM pipeline register.

---
 rtl/mem_access_unit_pkg.sv | 39 +++
 rtl/mem_access_unit_if.sv | 30 +++
 rtl/mem_load_align.sv | 29 ++
 rtl/mem_access_unit.sv | 204 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit_pkg
// Brief    : Shared constants, FSM state type and helpers for the MEM stage
// Revision : 1.0 - initial release
// ============================================================================
package mem_access_unit_pkg;

  // Exception codes. c_exc_none means the instruction carries no fault.
  localparam logic [4:0] c_exc_none = 5'h1f;
  localparam logic [4:0] c_exc_adel = 5'h04;
  localparam logic [4:0] c_exc_ades = 5'h05;
  localparam logic [4:0] c_exc_ov   = 5'h0c;

  // Data bus transfer sizes
  localparam logic [1:0] c_size_byte = 2'd0;
  localparam logic [1:0] c_size_half = 2'd1;
  localparam logic [1:0] c_size_word = 2'd2;

  // Bit positions of the memory operations inside inst_opreat[3:0]
  localparam int c_op_lh = 3;
  localparam int c_op_lw = 2;
  localparam int c_op_sh = 1;
  localparam int c_op_sw = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } mem_state_e;

  // A memory access only reaches the bus when the instruction is fault-free.
  function automatic logic is_mem_op(input logic [3:0] mem_bits, input logic [4:0] excep);
    return (|mem_bits) && (excep == c_exc_none);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit_if
// Brief    : Split address/data handshake data bus (MEM stage <-> memory)
// Revision : 1.0 - initial release
// ============================================================================
interface mem_access_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_ok, data_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_load_align.sv
`default_nettype none
// ============================================================================
// Module   : mem_load_align
// Brief    : Selects and extends load data returned by the bus (lh/lw)
// Revision : 1.0 - initial release
// ============================================================================
module mem_load_align (
  input  logic [31:0] rdata,
  input  logic        half_sel,   // address bit 1: upper halfword when set
  input  logic        is_lh,
  input  logic        is_lw,
  output logic [31:0] data
);

  logic [15:0] w_half;

  // Halfword lane select followed by sign extension; words pass unchanged
  always_comb begin
    w_half = half_sel ? rdata[31:16] : rdata[15:0];
    data   = '0;
    if (is_lh) begin
      data = {{16{w_half[15]}}, w_half};
    end else if (is_lw) begin
      data = rdata;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Brief    : MEM pipeline stage - EX/MEM register, data bus FSM, load merge
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic [9:0]        ex_inst_opreat,
  input  logic [4:0]        ex_wr_addr,
  input  logic              ex_wr_en,
  input  logic [DATA_W-1:0] ex_wr_data,
  input  logic              ex_hi_we,
  input  logic              ex_lo_we,
  input  logic [DATA_W-1:0] ex_hi,
  input  logic [DATA_W-1:0] ex_lo,
  input  logic [DATA_W-1:0] ex_reg_t,
  input  logic [ADDR_W-1:0] ex_mem_addr,
  input  logic [4:0]        ex_excep_code,
  input  logic [31:0]       ex_pc,
  output logic              ms_allowin,
  output logic              is_busbusy,
  input  logic              ws_allowin,
  output logic              ms_valid,
  output logic [9:0]        ms_inst_opreat,
  output logic [4:0]        ms_wr_addr,
  output logic              ms_wr_en,
  output logic [DATA_W-1:0] ms_wr_data,
  output logic              ms_hi_we,
  output logic              ms_lo_we,
  output logic [DATA_W-1:0] ms_hi,
  output logic [DATA_W-1:0] ms_lo,
  output logic [4:0]        ms_excep_code,
  output logic [31:0]       ms_pc,
  output logic              chk_wr_en,
  output logic [4:0]        chk_wr_addr,
  output logic [DATA_W-1:0] chk_wr_data,
  output logic              chk_data_ok,
  mem_access_unit_if.master bus
);

  mem_state_e        r_state, w_state_nxt;
  logic              r_valid;
  logic [9:0]        r_opreat;
  logic [4:0]        r_wr_addr;
  logic              r_wr_en;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_hi_we, r_lo_we;
  logic [DATA_W-1:0] r_hi, r_lo, r_reg_t;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [4:0]        r_excep;
  logic [31:0]       r_pc;

  logic              w_capture, w_ex_mem, w_enter_done, w_holds, w_pending;
  logic              w_is_lh, w_is_lw, w_is_sh, w_is_sw, w_is_load;
  logic              w_req, w_wr;
  logic [1:0]        w_size;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [31:0]       w_load_data;

  assign ms_allowin = (r_state == S_IDLE) & (~r_valid | ws_allowin);
  assign is_busbusy = ~ms_allowin;
  assign w_capture  = ex_valid & ms_allowin;
  assign w_ex_mem   = is_mem_op(ex_inst_opreat[3:0], ex_excep_code);

  assign w_is_lh   = r_opreat[c_op_lh];
  assign w_is_lw   = r_opreat[c_op_lw];
  assign w_is_sh   = r_opreat[c_op_sh];
  assign w_is_sw   = r_opreat[c_op_sw];
  assign w_is_load = w_is_lh | w_is_lw;

  // Same-cycle addr_ok + data_ok in REQ completes the access directly
  assign w_enter_done = ((r_state == S_REQ) & bus.data_addr_ok & bus.data_ok) |
                        ((r_state == S_WAIT) & bus.data_ok);
  assign w_pending    = (r_state == S_REQ) | (r_state == S_WAIT);
  assign w_holds      = (r_state != S_IDLE) | r_valid;

  mem_load_align u_load_align (
    .rdata    (bus.data_rdata),
    .half_sel (r_mem_addr[1]),
    .is_lh    (w_is_lh),
    .is_lw    (w_is_lw),
    .data     (w_load_data)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and bus drive; bus fields are only non-zero during REQ
  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_wr        = 1'b0;
    w_size      = c_size_byte;
    w_addr      = '0;
    w_wdata     = '0;
    case (r_state)
      S_IDLE: begin
        if (w_capture && w_ex_mem) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        w_req   = 1'b1;
        w_wr    = w_is_sh | w_is_sw;
        w_size  = (w_is_lh | w_is_sh) ? c_size_half : c_size_word;
        w_addr  = r_mem_addr;
        w_wdata = w_is_sh ? {2{r_reg_t[15:0]}} : r_reg_t;
        if (bus.data_addr_ok) w_state_nxt = bus.data_ok ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        if (bus.data_ok) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (ws_allowin) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.data_req   = w_req;
  assign bus.data_wr    = w_wr;
  assign bus.data_size  = w_size;
  assign bus.data_addr  = w_addr;
  assign bus.data_wdata = w_wdata;

  // Output valid: set by a non-memory capture or bus completion, cleared on WB accept
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
    end else if (w_capture) begin
      r_valid <= ~w_ex_mem;
    end else if (w_enter_done) begin
      r_valid <= 1'b1;
    end else if (ws_allowin) begin
      r_valid <= 1'b0;
    end
  end

  // EX/MEM pipeline register; load data replaces the write value on completion
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_opreat   <= '0;
      r_wr_addr  <= '0;
      r_wr_en    <= 1'b0;
      r_wr_data  <= '0;
      r_hi_we    <= 1'b0;
      r_lo_we    <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_reg_t    <= '0;
      r_mem_addr <= '0;
      r_excep    <= c_exc_none;
      r_pc       <= '0;
    end else if (w_capture) begin
      r_opreat   <= ex_inst_opreat;
      r_wr_addr  <= ex_wr_addr;
      r_wr_en    <= ex_wr_en;
      r_wr_data  <= ex_wr_data;
      r_hi_we    <= ex_hi_we;
      r_lo_we    <= ex_lo_we;
      r_hi       <= ex_hi;
      r_lo       <= ex_lo;
      r_reg_t    <= ex_reg_t;
      r_mem_addr <= ex_mem_addr;
      r_excep    <= ex_excep_code;
      r_pc       <= ex_pc;
    end else if (w_enter_done && w_is_load) begin
      r_wr_data  <= w_load_data;
    end
  end

  assign ms_valid       = r_valid;
  assign ms_inst_opreat = r_opreat;
  assign ms_wr_addr     = r_wr_addr;
  assign ms_wr_en       = r_wr_en;
  assign ms_wr_data     = r_wr_data;
  assign ms_hi_we       = r_hi_we;
  assign ms_lo_we       = r_lo_we;
  assign ms_hi          = r_hi;
  assign ms_lo          = r_lo;
  assign ms_excep_code  = r_excep;
  assign ms_pc          = r_pc;

  // Forwarding view: present while the stage owns an instruction; load data not yet usable
  assign chk_wr_en   = w_holds & r_wr_en;
  assign chk_wr_addr = w_holds ? r_wr_addr : 5'd0;
  assign chk_wr_data = w_holds ? r_wr_data : '0;
  assign chk_data_ok = w_holds & ~(w_pending & w_is_load);

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mem_access_unit
// Brief    : Self-checking bench for the MEM stage with a bus responder
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ex_valid = 1'b0;
  logic [9:0]  ex_inst_opreat = '0;
  logic [4:0]  ex_wr_addr = '0;
  logic        ex_wr_en = 1'b0;
  logic [31:0] ex_wr_data = '0;
  logic        ex_hi_we = 1'b0, ex_lo_we = 1'b0;
  logic [31:0] ex_hi = '0, ex_lo = '0, ex_reg_t = '0, ex_mem_addr = '0;
  logic [4:0]  ex_excep_code = c_exc_none;
  logic [31:0] ex_pc = '0;
  logic        ms_allowin, is_busbusy;
  logic        ws_allowin = 1'b0;
  logic        ms_valid;
  logic [9:0]  ms_inst_opreat;
  logic [4:0]  ms_wr_addr;
  logic        ms_wr_en;
  logic [31:0] ms_wr_data;
  logic        ms_hi_we, ms_lo_we;
  logic [31:0] ms_hi, ms_lo;
  logic [4:0]  ms_excep_code;
  logic [31:0] ms_pc;
  logic        chk_wr_en;
  logic [4:0]  chk_wr_addr;
  logic [31:0] chk_wr_data;
  logic        chk_data_ok;

  mem_access_unit_if bus ();

  mem_access_unit dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_inst_opreat(ex_inst_opreat), .ex_wr_addr(ex_wr_addr),
    .ex_wr_en(ex_wr_en), .ex_wr_data(ex_wr_data), .ex_hi_we(ex_hi_we), .ex_lo_we(ex_lo_we),
    .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_reg_t(ex_reg_t), .ex_mem_addr(ex_mem_addr),
    .ex_excep_code(ex_excep_code), .ex_pc(ex_pc),
    .ms_allowin(ms_allowin), .is_busbusy(is_busbusy), .ws_allowin(ws_allowin),
    .ms_valid(ms_valid), .ms_inst_opreat(ms_inst_opreat), .ms_wr_addr(ms_wr_addr),
    .ms_wr_en(ms_wr_en), .ms_wr_data(ms_wr_data), .ms_hi_we(ms_hi_we), .ms_lo_we(ms_lo_we),
    .ms_hi(ms_hi), .ms_lo(ms_lo), .ms_excep_code(ms_excep_code), .ms_pc(ms_pc),
    .chk_wr_en(chk_wr_en), .chk_wr_addr(chk_wr_addr), .chk_wr_data(chk_wr_data),
    .chk_data_ok(chk_data_ok),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  op;
    logic [4:0]  wa;
    logic        we;
    logic [31:0] wd;
    logic        hwe, lwe;
    logic [31:0] hi, lo, rt, addr, pc;
    logic [4:0]  exc;
  } inst_t;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Architectural load result: lw returns the word, lh the sign-extended addressed halfword
  function automatic logic [31:0] ref_result(input inst_t in, input logic [31:0] rdata);
    logic [15:0] h;
    h = in.addr[1] ? rdata[31:16] : rdata[15:0];
    if (in.op[3]) return {{16{h[15]}}, h};
    if (in.op[2]) return rdata;
    return in.wd;
  endfunction

  function automatic inst_t mk(input logic [9:0] op, input logic [31:0] addr,
                               input logic [31:0] rt, input logic [31:0] wd, input logic [4:0] exc);
    inst_t t;
    t.op = op; t.addr = addr; t.rt = rt; t.wd = wd; t.exc = exc;
    t.wa = 5'($urandom); t.we = (op[3] | op[2] | !(op[1] | op[0]));
    t.hwe = 1'($urandom); t.lwe = 1'($urandom);
    t.hi = $urandom; t.lo = $urandom; t.pc = $urandom;
    return t;
  endfunction

  function automatic inst_t rand_inst();
    inst_t t;
    logic [9:0] op;
    logic [31:0] a;
    logic [4:0] e;
    int k;
    k  = $urandom_range(0, 4);
    op = {6'($urandom), 4'b0000};
    a  = $urandom;
    if (k == 1) begin op[3] = 1'b1; a[0] = 1'b0; end
    if (k == 2) begin op[2] = 1'b1; a[1:0] = 2'b00; end
    if (k == 3) begin op[1] = 1'b1; a[0] = 1'b0; end
    if (k == 4) begin op[0] = 1'b1; a[1:0] = 2'b00; end
    case ($urandom_range(0, 7))
      0: e = c_exc_adel;
      1: e = c_exc_ades;
      2: e = c_exc_ov;
      default: e = c_exc_none;
    endcase
    t = mk(op, a, $urandom, $urandom, e);
    return t;
  endfunction

  // Present one instruction, serve its bus traffic, then hold WB off for 'stall' cycles
  task automatic run_op(input inst_t in, input int addr_lat, input int data_lat,
                        input logic [31:0] rdata, input int stall);
    logic        is_mem, is_load;
    logic [31:0] exp_wd, exp_wdata;
    logic [1:0]  exp_size;
    int          g;
    is_mem    = (in.op[3:0] != 4'b0000) && (in.exc == c_exc_none);
    is_load   = is_mem && (in.op[3] || in.op[2]);
    exp_wd    = is_load ? ref_result(in, rdata) : in.wd;
    exp_size  = (in.op[3] || in.op[1]) ? 2'd1 : 2'd2;
    exp_wdata = in.op[1] ? {in.rt[15:0], in.rt[15:0]} : in.rt;

    g = 0;
    while (!ms_allowin && g < 20) begin @(negedge clk); g++; end
    check("allowin_before_issue", ms_allowin, 1);
    ex_valid = 1'b1; ex_inst_opreat = in.op; ex_wr_addr = in.wa; ex_wr_en = in.we;
    ex_wr_data = in.wd; ex_hi_we = in.hwe; ex_lo_we = in.lwe; ex_hi = in.hi; ex_lo = in.lo;
    ex_reg_t = in.rt; ex_mem_addr = in.addr; ex_excep_code = in.exc; ex_pc = in.pc;
    ws_allowin = 1'b0;
    @(negedge clk);
    ex_valid = 1'b0; ex_wr_data = $urandom; ex_mem_addr = $urandom; ex_reg_t = $urandom;

    if (is_mem) begin
      check("req_first", bus.data_req, 1);
      check("req_addr", bus.data_addr, in.addr);
      check("req_size", bus.data_size, exp_size);
      check("req_wr", bus.data_wr, in.op[1] | in.op[0]);
      if (!is_load) check("req_wdata", bus.data_wdata, exp_wdata);
      check("busy_req", is_busbusy, 1);
      check("valid_req", ms_valid, 0);
      check("chk_ok_req", chk_data_ok, !is_load);
      for (int k = 0; k < addr_lat; k++) begin
        @(negedge clk);
        check("req_held", bus.data_req, 1);
        check("addr_held", bus.data_addr, in.addr);
      end
      bus.data_addr_ok = 1'b1;
      if (data_lat == 0) begin bus.data_ok = 1'b1; bus.data_rdata = rdata; end
      @(negedge clk);
      bus.data_addr_ok = 1'b0; bus.data_ok = 1'b0; bus.data_rdata = $urandom;
      for (int k = 0; k < data_lat; k++) begin
        check("req_dropped", bus.data_req, 0);
        check("busy_wait", is_busbusy, 1);
        check("valid_wait", ms_valid, 0);
        if (k == data_lat - 1) begin bus.data_ok = 1'b1; bus.data_rdata = rdata; end
        @(negedge clk);
      end
      bus.data_ok = 1'b0; bus.data_rdata = $urandom;
    end

    for (int k = 0; k <= stall; k++) begin
      check("ms_valid", ms_valid, 1);
      check("ms_wr_data", ms_wr_data, exp_wd);
      check("no_req_done", bus.data_req, 0);
      check("busy_stalled", is_busbusy, 1);
      if (k == 0 || k == stall) begin
        check("ms_op", ms_inst_opreat, in.op);
        check("ms_wr_addr", ms_wr_addr, in.wa);
        check("ms_wr_en", ms_wr_en, in.we);
        check("ms_hilo_we", {ms_hi_we, ms_lo_we}, {in.hwe, in.lwe});
        check("ms_hi", ms_hi, in.hi);
        check("ms_lo", ms_lo, in.lo);
        check("ms_excep", ms_excep_code, in.exc);
        check("ms_pc", ms_pc, in.pc);
        check("chk_fwd", {chk_wr_en, chk_wr_addr, chk_wr_data, chk_data_ok},
              {in.we, in.wa, exp_wd, 1'b1});
      end
      if (k == stall) begin
        ws_allowin = 1'b1;
        #1 check("busy_on_accept", is_busbusy, is_mem);
      end
      @(negedge clk);
    end
    check("valid_cleared", ms_valid, 0);
    check("chk_en_cleared", chk_wr_en, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    inst_t t;
    bus.data_addr_ok = 1'b0;
    bus.data_ok      = 1'b0;
    bus.data_rdata   = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", ms_valid, 0);
    check("rst_req", bus.data_req, 0);
    check("rst_excep", ms_excep_code, c_exc_none);
    check("rst_wr_data", ms_wr_data, 0);
    check("rst_allowin", ms_allowin, 1);
    reset = 1'b1;
    @(negedge clk);

    // ALU result, single-cycle pass-through
    t = mk(10'h010, 32'h0, 32'h0, 32'h5, c_exc_none); t.wa = 5'd3; t.we = 1'b1;
    run_op(t, 0, 0, 32'h0, 0);
    // lw with separated address and data phases
    run_op(mk(10'h004, 32'h100, 32'h0, 32'h0, c_exc_none), 1, 2, 32'hDEADBEEF, 2);
    // lh upper and lower halves
    run_op(mk(10'h008, 32'h102, 32'h0, 32'h0, c_exc_none), 0, 1, 32'h80011234, 0);
    run_op(mk(10'h008, 32'h100, 32'h0, 32'h0, c_exc_none), 2, 1, 32'h80011234, 1);
    // sh lane replication
    run_op(mk(10'h002, 32'h206, 32'hAAAA5555, 32'h0, c_exc_none), 1, 1, 32'h0, 0);
    // faulting lw bypasses the bus
    run_op(mk(10'h004, 32'h101, 32'h0, 32'h0, c_exc_adel), 0, 0, 32'h0, 1);
    // address and data accepted in the same cycle
    run_op(mk(10'h004, 32'h300, 32'h0, 32'h0, c_exc_none), 0, 0, 32'h12345678, 0);

    // Reset while waiting for load data
    ex_valid = 1'b1; ex_inst_opreat = 10'h004; ex_mem_addr = 32'h400; ex_wr_en = 1'b1;
    ex_excep_code = c_exc_none; ws_allowin = 1'b0;
    @(negedge clk);
    ex_valid = 1'b0;
    bus.data_addr_ok = 1'b1;
    @(negedge clk);
    bus.data_addr_ok = 1'b0;
    check("wait_before_reset", {bus.data_req, is_busbusy}, 2'b01);
    reset = 1'b0;
    #1;
    check("async_rst_bus", {bus.data_req, bus.data_addr}, 33'd0);
    check("async_rst_ms", {ms_valid, ms_wr_data, ms_pc, chk_wr_en}, 66'd0);
    check("async_rst_excep", ms_excep_code, c_exc_none);
    check("async_rst_busy", is_busbusy, 0);
    @(negedge clk);
    reset = 1'b1;
    bus.data_ok = 1'b1; bus.data_rdata = 32'hCAFEF00D;
    @(negedge clk);
    bus.data_ok = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("stray_data_ok", {ms_valid, bus.data_req, chk_data_ok}, 3'b000);
      @(negedge clk);
    end

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      run_op(rand_inst(), $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
             $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
